// File: rtl/merge_sched_pkg.sv
// merge_sched_pkg: shared defaults, FSM states and width helper for the merge frame scheduler
package merge_sched_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_IN_LEN  = 10;
    localparam int DEF_OUT_LEN = 16;

    typedef enum logic [1:0] {
        FILL,
        EMIT,
        EMIT_TAIL
    } state_e;

    function automatic int min_bit_width(input int v);
        return (v < 2) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/merge_core.sv
// merge_core: concatenates the buffered words with the incoming block, MSB-first, zero-filled
module merge_core
    import merge_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int IN_LEN  = DEF_IN_LEN,
    parameter int OUT_LEN = DEF_OUT_LEN
) (
    input  logic [WIDTH*OUT_LEN-1:0]                  buf_i,
    input  logic [min_bit_width(OUT_LEN)-1:0]         fill_i,
    input  logic [WIDTH*IN_LEN-1:0]                   blk_i,
    input  logic [min_bit_width(IN_LEN)-1:0]          len_i,
    output logic [WIDTH*(OUT_LEN+IN_LEN)-1:0]         cat_o,
    output logic [min_bit_width(OUT_LEN+IN_LEN)-1:0]  total_o
);

    localparam int TOT = OUT_LEN + IN_LEN;
    localparam int LWT = min_bit_width(TOT);

    assign total_o = LWT'(fill_i) + LWT'(len_i);

    // buffer words first, then the block's valid words right behind them
    always_comb begin
        cat_o = '0;
        for (int p = 0; p < OUT_LEN; p++)
            if (p < int'(fill_i))
                cat_o[WIDTH*(TOT-1-p) +: WIDTH] = buf_i[WIDTH*(OUT_LEN-1-p) +: WIDTH];
        for (int i = 0; i < IN_LEN; i++)
            if (i < int'(len_i))
                cat_o[WIDTH*(TOT-1-int'(fill_i)-i) +: WIDTH] = blk_i[WIDTH*(IN_LEN-1-i) +: WIDTH];
    end

endmodule

// File: rtl/merge_frame_scheduler.sv
// merge_frame_scheduler: packs variable-length input blocks into fixed-size output frames
module merge_frame_scheduler
    import merge_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int IN_LEN  = DEF_IN_LEN,
    parameter int OUT_LEN = DEF_OUT_LEN
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH*IN_LEN-1:0]            in_data,
    input  logic [min_bit_width(IN_LEN)-1:0]   in_len,
    input  logic                               in_flush,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH*OUT_LEN-1:0]           out_data,
    output logic [min_bit_width(OUT_LEN)-1:0]  out_len
);

    localparam int TOT = OUT_LEN + IN_LEN;
    localparam int LWI = min_bit_width(IN_LEN);
    localparam int LWO = min_bit_width(OUT_LEN);
    localparam int LWT = min_bit_width(TOT);

    state_e                   state_q, state_d;
    logic [WIDTH*OUT_LEN-1:0] buf_q, buf_d, out_data_q, out_data_d;
    logic [LWO-1:0]           fill_q, fill_d, out_len_q, out_len_d;
    logic [LWI-1:0]           len_c;
    logic [WIDTH*TOT-1:0]     cat_c, shl_c;
    logic [LWT-1:0]           total_c;
    logic [WIDTH*OUT_LEN-1:0] frame_c, rem_c;

    assign len_c = (in_len > LWI'(IN_LEN)) ? LWI'(IN_LEN) : in_len;

    merge_core #(
        .WIDTH   (WIDTH),
        .IN_LEN  (IN_LEN),
        .OUT_LEN (OUT_LEN)
    ) u_core (
        .buf_i   (buf_q),
        .fill_i  (fill_q),
        .blk_i   (in_data),
        .len_i   (len_c),
        .cat_o   (cat_c),
        .total_o (total_c)
    );

    assign shl_c     = cat_c << (WIDTH*OUT_LEN);
    assign frame_c   = cat_c[WIDTH*TOT-1 -: WIDTH*OUT_LEN];
    assign rem_c     = shl_c[WIDTH*TOT-1 -: WIDTH*OUT_LEN];
    assign in_ready  = state_q == FILL;
    assign out_valid = state_q != FILL;
    assign out_data  = out_data_q;
    assign out_len   = out_len_q;

    // next-state: pack, split off full frames, and drain the tail after a flush
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        fill_d     = fill_q;
        out_data_d = out_data_q;
        out_len_d  = out_len_q;
        unique case (state_q)
            FILL: if (in_valid) begin
                if (total_c >= LWT'(OUT_LEN)) begin
                    out_data_d = frame_c;
                    out_len_d  = LWO'(OUT_LEN);
                    buf_d      = rem_c;
                    fill_d     = LWO'(total_c - LWT'(OUT_LEN));
                    state_d    = (in_flush && total_c != LWT'(OUT_LEN)) ? EMIT_TAIL : EMIT;
                end else if (!in_flush) begin
                    buf_d  = frame_c;
                    fill_d = LWO'(total_c);
                end else if (total_c != '0) begin
                    out_data_d = frame_c;
                    out_len_d  = LWO'(total_c);
                    buf_d      = '0;
                    fill_d     = '0;
                    state_d    = EMIT;
                end
            end
            EMIT: if (out_ready) state_d = FILL;
            EMIT_TAIL: if (out_ready) begin
                out_data_d = buf_q;
                out_len_d  = fill_q;
                buf_d      = '0;
                fill_d     = '0;
                state_d    = EMIT;
            end
            default: state_d = FILL;
        endcase
    end

    // state, buffer and output frame registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FILL;
            buf_q      <= '0;
            fill_q     <= '0;
            out_data_q <= '0;
            out_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            out_data_q <= out_data_d;
            out_len_q  <= out_len_d;
        end
    end

endmodule

// File: tb/tb_merge_frame_scheduler.sv
// tb_merge_frame_scheduler: table-driven directed checks of block packing, flush and tail frames
module tb_merge_frame_scheduler;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [159:0] in_data;
    logic [3:0]   in_len;
    logic         in_flush;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [4:0]   out_len;

    int checks = 0;
    int failures = 0;

    merge_frame_scheduler #(.WIDTH(16), .IN_LEN(10), .OUT_LEN(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_len   (out_len)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  len;
        logic        flush;
        logic [15:0] first;
        logic        ov;
        logic [4:0]  olen;
        logic [15:0] ofirst;
        logic        tail;
        logic [4:0]  tlen;
        logic [15:0] tfirst;
        int          stall;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [3:0] len, input logic flush, input logic [15:0] first,
                                input logic ov, input logic [4:0] olen, input logic [15:0] ofirst,
                                input logic tail, input logic [4:0] tlen, input logic [15:0] tfirst,
                                input int stall);
        vec_t v;
        v.len = len; v.flush = flush; v.first = first;
        v.ov = ov; v.olen = olen; v.ofirst = ofirst;
        v.tail = tail; v.tlen = tlen; v.tfirst = tfirst; v.stall = stall;
        return v;
    endfunction

    function automatic logic [159:0] blk(input logic [15:0] first, input int n);
        logic [159:0] b;
        for (int k = 0; k < 10; k++)
            b[16*(9-k) +: 16] = (k < n) ? first + 16'(k) : 16'hDEAD;
        return b;
    endfunction

    function automatic logic [255:0] frm(input logic [15:0] first, input int n);
        logic [255:0] f;
        for (int k = 0; k < 16; k++)
            f[16*(15-k) +: 16] = (k < n) ? first + 16'(k) : 16'h0000;
        return f;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] len, input logic flush, input logic [15:0] first);
        @(negedge clock);
        chk("in_ready_before_accept", 256'(in_ready), 256'(1'b1));
        in_valid = 1'b1;
        in_len   = len;
        in_flush = flush;
        in_data  = blk(first, int'(len));
        @(negedge clock);
        in_valid = 1'b0;
        in_flush = 1'b0;
        in_data  = {10{16'hBEEF}};
    endtask

    initial begin
        vecs[0]  = mk(4'd4,  1'b0, 16'h0001, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 0);
        vecs[1]  = mk(4'd4,  1'b0, 16'h0005, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 0);
        vecs[2]  = mk(4'd10, 1'b0, 16'h0009, 1'b1, 5'd16, 16'h0001, 1'b0, 5'd0, 16'h0000, 5);
        vecs[3]  = mk(4'd3,  1'b1, 16'h0013, 1'b1, 5'd5,  16'h0011, 1'b0, 5'd0, 16'h0000, 0);
        vecs[4]  = mk(4'd0,  1'b1, 16'h0000, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 0);
        vecs[5]  = mk(4'd10, 1'b0, 16'h0020, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 0);
        vecs[6]  = mk(4'd2,  1'b0, 16'h002A, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 0);
        vecs[7]  = mk(4'd10, 1'b1, 16'h002C, 1'b1, 5'd16, 16'h0020, 1'b1, 5'd6, 16'h0030, 1);
        vecs[8]  = mk(4'd15, 1'b0, 16'h0040, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 0);
        vecs[9]  = mk(4'd6,  1'b0, 16'h004A, 1'b1, 5'd16, 16'h0040, 1'b0, 5'd0, 16'h0000, 0);
        vecs[10] = mk(4'd10, 1'b0, 16'h0050, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd0, 16'h0000, 0);
        vecs[11] = mk(4'd6,  1'b1, 16'h005A, 1'b1, 5'd16, 16'h0050, 1'b0, 5'd0, 16'h0000, 2);
        vecs[12] = mk(4'd1,  1'b1, 16'h0060, 1'b1, 5'd1,  16'h0060, 1'b0, 5'd0, 16'h0000, 0);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_len    = '0;
        in_flush  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset_in_ready", 256'(in_ready), 256'(1'b1));
        chk("reset_out_valid", 256'(out_valid), 256'(1'b0));
        chk("reset_out_len", 256'(out_len), 256'(5'd0));
        chk("reset_out_data", out_data, 256'(0));

        for (int v = 0; v < 13; v++) begin
            send(vecs[v].len, vecs[v].flush, vecs[v].first);
            chk($sformatf("v%0d_out_valid", v), 256'(out_valid), 256'(vecs[v].ov));
            if (vecs[v].ov) begin
                chk($sformatf("v%0d_out_len", v), 256'(out_len), 256'(vecs[v].olen));
                chk($sformatf("v%0d_out_data", v), out_data, frm(vecs[v].ofirst, int'(vecs[v].olen)));
                for (int s = 0; s < vecs[v].stall; s++) begin
                    @(negedge clock);
                    chk($sformatf("v%0d_stall%0d_valid", v, s), 256'(out_valid), 256'(1'b1));
                    chk($sformatf("v%0d_stall%0d_ready", v, s), 256'(in_ready), 256'(1'b0));
                    chk($sformatf("v%0d_stall%0d_len", v, s), 256'(out_len), 256'(vecs[v].olen));
                    chk($sformatf("v%0d_stall%0d_data", v, s), out_data, frm(vecs[v].ofirst, int'(vecs[v].olen)));
                end
                out_ready = 1'b1;
                chk($sformatf("v%0d_bubble_in_ready", v), 256'(in_ready), 256'(1'b0));
                @(negedge clock);
                out_ready = 1'b0;
                if (vecs[v].tail) begin
                    chk($sformatf("v%0d_tail_valid", v), 256'(out_valid), 256'(1'b1));
                    chk($sformatf("v%0d_tail_len", v), 256'(out_len), 256'(vecs[v].tlen));
                    chk($sformatf("v%0d_tail_data", v), out_data, frm(vecs[v].tfirst, int'(vecs[v].tlen)));
                    chk($sformatf("v%0d_tail_in_ready", v), 256'(in_ready), 256'(1'b0));
                    out_ready = 1'b1;
                    @(negedge clock);
                    out_ready = 1'b0;
                end
                chk($sformatf("v%0d_done_valid", v), 256'(out_valid), 256'(1'b0));
                chk($sformatf("v%0d_done_in_ready", v), 256'(in_ready), 256'(1'b1));
            end
        end

        send(4'd10, 1'b0, 16'h0070);
        send(4'd10, 1'b0, 16'h007A);
        chk("pre_reset_valid", 256'(out_valid), 256'(1'b1));
        chk("pre_reset_data", out_data, frm(16'h0070, 16));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_emit_reset_valid", 256'(out_valid), 256'(1'b0));
        chk("mid_emit_reset_len", 256'(out_len), 256'(5'd0));
        chk("mid_emit_reset_data", out_data, 256'(0));
        chk("mid_emit_reset_in_ready", 256'(in_ready), 256'(1'b1));
        send(4'd1, 1'b1, 16'h0090);
        chk("post_reset_flush_valid", 256'(out_valid), 256'(1'b1));
        chk("post_reset_flush_len", 256'(out_len), 256'(5'd1));
        chk("post_reset_flush_data", out_data, frm(16'h0090, 1));
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("post_reset_done_valid", 256'(out_valid), 256'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/merge_frame_scheduler.md
MERGE_FRAME_SCHEDULER -- requirements
Module: merge_frame_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bits per data word.
REQ-002 SHALL have parameter IN_LEN, default 10: maximum words per input block.
REQ-003 SHALL have parameter OUT_LEN, default 16: words per output frame. OUT_LEN >= IN_LEN is required.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input-block handshake.
REQ-007 SHALL have port in_data, input, WIDTH*IN_LEN bits: word 0 in the most-significant slice; words at index >= in_len are ignored.
REQ-008 SHALL have port in_len, input, MinBitWidth(IN_LEN) bits: number of valid words in the block.
REQ-009 SHALL have port in_flush, input, 1 bit: qualified by in_valid; forces emission of all buffered words after this block is appended.
REQ-010 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output-frame handshake.
REQ-011 SHALL have port out_data, output, WIDTH*OUT_LEN bits: frame with word 0 in the most-significant slice; words at index >= out_len are zero.
REQ-012 SHALL have port out_len, output, MinBitWidth(OUT_LEN) bits: number of valid words in the frame.

Function
REQ-013 SHALL hold an OUT_LEN-word packing buffer and a fill count in 0..OUT_LEN-1; words are packed MSB-first, in arrival order, with no gaps.
REQ-014 SHALL implement three states:
- FILL: in_ready=1, out_valid=0.
- EMIT: in_ready=0, out_valid=1.
- EMIT_TAIL: in_ready=0, out_valid=1.
REQ-015 SHALL treat an in_len value greater than IN_LEN as IN_LEN.
REQ-016 SHALL, on acceptance in FILL with flush=0 and total = fill + in_len < OUT_LEN, append the block, set fill=total, and remain in FILL.
REQ-017 SHALL, on acceptance in FILL with total >= OUT_LEN (any flush), register words 0..OUT_LEN-1 to out_data with out_len=OUT_LEN, move the remaining total-OUT_LEN words to buffer positions 0.., and set fill=total-OUT_LEN.
- Next state is EMIT_TAIL if flush=1 and the remainder > 0.
- Otherwise next state is EMIT.
REQ-018 SHALL, on acceptance in FILL with flush=1 and 0 < total < OUT_LEN, register the packed words to out_data with out_len=total, set fill=0, and go to EMIT.
REQ-019 SHALL, on acceptance in FILL with flush=1 and total=0, emit no frame and remain in FILL.
REQ-020 SHALL assert out_valid in the cycle after the accepting edge (latency 1), with no combinational path from in_* to out_*.
REQ-021 SHALL hold out_data and out_len stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on the EMIT handshake (out_valid & out_ready), return to FILL.
REQ-023 SHALL, on the EMIT_TAIL handshake, load the buffer contents as a frame with out_len=fill, zero-padded, set fill=0, and go to EMIT.
REQ-024 SHALL keep in_ready low in EMIT and EMIT_TAIL even when out_ready=1, giving a one-cycle bubble per frame.

Reset
REQ-025 SHALL, when reset is high at a rising edge, set: state=FILL, fill=0, out_valid=0, out_len=0, out_data=0, buffer=0. in_ready SHALL read 1 from the first cycle after reset.
REQ-026 SHALL discard a pending frame and all buffered words when reset occurs mid-EMIT or mid-EMIT_TAIL.

Structure
REQ-027 SHALL take the state enum, the MinBitWidth function, and the default WIDTH/IN_LEN/OUT_LEN constants from shared package merge_sched_pkg.
REQ-028 SHALL instantiate one combinational sub-module, merge_core, which concatenates buffer (fill) with block (in_len) into OUT_LEN+IN_LEN words; all registers, including the split into frame and remainder, live in merge_frame_scheduler.

Verification (WIDTH=16, IN_LEN=10, OUT_LEN=16)
REQ-029 Reset, then two blocks of len 4 (words 0x0001..0x0004, then 0x0005..0x0008), flush=0 -> out_valid stays 0, fill=8.
REQ-030 From fill=8, a len-10 block (0x0009..0x0012) -> next cycle out_valid=1, out_len=16, out_data=0x0001..0x0010; after handshake, fill=2 holding 0x0011, 0x0012.
REQ-031 out_ready=0 for 5 cycles while out_valid=1 -> out_data/out_len unchanged and in_ready=0 throughout; frame consumed on the first out_ready=1.
REQ-032 fill=2 plus a len-3 block with flush=1 -> out_len=5, words 5..15 all zero, fill=0 afterwards. Flush with len 0 on an empty buffer -> no out_valid.
REQ-033 fill=12 plus a len-10 block with flush=1 -> first frame out_len=16, then an EMIT_TAIL frame out_len=6, then FILL with fill=0.
REQ-034 Reset asserted while in EMIT -> out_valid=0 and fill=0 in the next cycle. An in_len=15 block is treated as 10 words.
